spi_slave_sync: RTL and testbench
=================================

# spi_slave_sync

Parametrised SPI slave that runs entirely in the system clock domain: `sclk`, `ss_n` and `mosi` are oversampled through 2-FF synchronisers rather than used as clocks. It supports all four SPI modes, any word width, and multiple back-to-back words per frame. Data moves through valid/ready handshakes on both sides: a one-word TX holding buffer and an RX output register. It sits between an off-chip SPI master and the on-chip register/FIFO logic.

## Interface
- `M`, default 8: word width in bits, 2..32.
- `MODE`, default 0: SPI mode 0..3; CPOL = MODE[1], CPHA = MODE[0].
- `clk` in 1: system clock, rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `sclk` in 1: SPI clock from master, asynchronous.
- `ss_n` in 1: slave select, active-low, asynchronous.
- `mosi` in 1: serial data in, asynchronous.
- `miso` out 1: serial data out, MSB first.
- `miso_oe` out 1: MISO output enable; high while the frame is active.
- `tx_data` in M: word to transmit.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: TX holding buffer is empty.
- `rx_data` out M: last received word.
- `rx_valid` out 1: `rx_data` holds an unread word.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `err` out 2: sticky error flags; bit 0 = TX underrun, bit 1 = RX overrun.
- `err_clr` in 1: one-cycle pulse that clears `err`.

## Operation
- **Synchronisers.** Reset values: `sclk` sync = CPOL, `ss_n` sync = 1, `mosi` sync = 0.
- **Edge detection.** A third register on `sclk` detects edges.
  - Leading edge = transition away from CPOL.
  - Trailing edge = transition back to CPOL.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1. The other edge is the shift edge.
- **FSM: IDLE and ACTIVE.**
  - IDLE→ACTIVE on synced `ss_n` fall.
  - ACTIVE→IDLE on synced `ss_n` rise.
  - `sclk` edges are ignored in IDLE.
- **Bit counter.** Width ceil(log2 M). Cleared on entry to ACTIVE. Increments on each sample edge and wraps M-1→0.
- **RX.**
  - Each sample edge shifts: rx_sr <= {rx_sr[M-2:0], mosi_sync}.
  - On the sample edge where the counter is M-1, the full word is copied to `rx_data` and `rx_valid` is set.
  - `rx_valid` clears when `rx_valid && rx_ready`.
- **TX.** `miso` = tx_sr[M-1] while ACTIVE, 0 in IDLE.
  - Load points when CPHA=0: entry to ACTIVE, and the shift edge that follows a word-completing sample edge.
  - Load point when CPHA=1: a shift edge with counter = 0.
  - At a load point, tx_sr <= buffer if full (buffer then empties); otherwise tx_sr <= 0 and err[0] is set.
  - At all other shift edges, tx_sr shifts left by 1 with 0 fill.
- **TX buffer.** `tx_ready` = buffer empty. The buffer is written when `tx_valid && tx_ready`.
- **Boundary conditions.**
  - Word completes while `rx_valid && !rx_ready`: `rx_data` is overwritten and err[1] is set.
  - Word completes in the same cycle as `rx_valid && rx_ready`: the new word is loaded, `rx_valid` stays 1, no error.
  - Load point in the same cycle as a buffer write into an empty buffer: tx_sr loads 0 (underrun), and the written word stays in the buffer for the next load point.
  - `ss_n` rises mid-word: partial RX bits are discarded, no `rx_valid`, the counter clears, and the word in tx_sr is lost. The holding buffer is untouched.
  - `err_clr` in the same cycle as a new error: the error wins.
- **Reset values.** `clr` returns the FSM to IDLE. Outputs: `miso`=0, `miso_oe`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `err`=0. TX buffer and shift registers are cleared.

## Timing
- An internal action occurs 3 clk after the corresponding pin edge: 2 sync stages + 1 edge register. Allow +1 clk of synchroniser uncertainty.
- `rx_valid` rises 3–4 clk after the final sample edge at the pin.
- `miso` changes 3–4 clk after a pin shift edge or after the `ss_n` fall.
- Master constraints:
  - sclk high and low times ≥ 4 clk each, so f_sclk ≤ f_clk/8.
  - First sclk edge ≥ 5 clk after `ss_n` falls.
  - `ss_n` high time ≥ 4 clk.
- `tx_ready` drops the cycle after an accept and rises the cycle after a load point consumes the buffer.
- Back-to-back frames with no idle words are supported. Throughput is 1 word per M sclk periods.

## Configuration
- `SPI_SLAVE_SYNC_ERR_EN` defined: `err` is implemented as described, including sticky bits and `err_clr`.
- Not defined: `err` is tied to 2'b00 and `err_clr` is ignored. Underrun and overrun behaviour on the data paths is unchanged (zeros are sent on underrun, `rx_data` is overwritten on overrun).

## Test plan
- M=8, MODE=0: preload `tx_data`=0xA5, master sends 0x3C → `rx_data`=0x3C with a one-word `rx_valid` event; master captures 0xA5.
- M=16, MODE=3: two words in one frame, 0x1234 then 0xBEEF, buffer refilled between words → two RX words in order; master captures both TX words; err=0.
- M=8, MODE=1, empty TX buffer → master captures 0x00; err=2'b01; after `err_clr` pulse, err=2'b00.
- M=8, MODE=2, `rx_ready` held low across 2 words 0x11, 0x22 → `rx_data`=0x22, `rx_valid`=1, err[1]=1.
- `ss_n` raised after 5 of 8 bits, then a full frame 0x5A → no `rx_valid` for the aborted word; next `rx_data`=0x5A.
- `clr` asserted mid-frame → all outputs return to reset values within the same cycle (asynchronous); `tx_ready`=1.

Source files
------------

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: clk-domain SPI slave (modes 0-3, M-bit words, valid/ready both sides); define SPI_SLAVE_SYNC_ERR_EN for sticky err flags
module spi_slave_sync #(
  parameter int M = 8,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         sclk,
  input  logic         ss_n,
  input  logic         mosi,
  output logic         miso,
  output logic         miso_oe,
  input  logic [M-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [M-1:0] rx_data,
  output logic         rx_valid,
  input  logic         rx_ready,
  output logic [1:0]   err,
  input  logic         err_clr
);
  localparam logic CPOL = MODE[1];
  localparam logic CPHA = MODE[0];
  localparam int CW = $clog2(M);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;
  logic sclk_s1, sclk_s2, sclk_d, ss_s1, ss_s2, mosi_s1, mosi_s2;
  logic [CW-1:0] cnt;
  logic [M-1:0] rx_sr, tx_sr, tx_buf, rx_nx;
  logic buf_full, act, entry, leave, lead, trail, samp, shft, done, ld, wr;
  logic [1:0] err_set;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      {sclk_s1, sclk_s2, sclk_d} <= {3{CPOL}};
      {ss_s1, ss_s2} <= 2'b11;
      {mosi_s1, mosi_s2} <= 2'b00;
    end else begin
      {sclk_s1, sclk_s2, sclk_d} <= {sclk, sclk_s1, sclk_s2};
      {ss_s1, ss_s2} <= {ss_n, ss_s1};
      {mosi_s1, mosi_s2} <= {mosi, mosi_s1};
    end
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = ss_s2 ? IDLE : ACTIVE;
  end
  always_comb begin
    miso_oe = state == ACTIVE;
    miso = miso_oe && tx_sr[M-1];
  end
  assign act = state == ACTIVE;
  assign entry = !act && state_nx == ACTIVE;
  assign leave = act && state_nx == IDLE;
  assign lead = sclk_s2 != CPOL && sclk_d == CPOL;
  assign trail = sclk_s2 == CPOL && sclk_d != CPOL;
  assign samp = act && (CPHA ? trail : lead);
  assign shft = act && (CPHA ? lead : trail);
  assign done = samp && cnt == CW'(M - 1);
  // CPHA=0 preloads on select; otherwise the first shift edge of a word loads
  assign ld = (shft && cnt == '0) || (!CPHA && entry);
  assign wr = tx_valid && tx_ready;
  assign tx_ready = !buf_full;
  assign rx_nx = {rx_sr[M-2:0], mosi_s2};
  assign err_set = {done && rx_valid && !rx_ready, ld && !buf_full};
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
      rx_sr <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_sr <= '0;
      tx_buf <= '0;
      buf_full <= 1'b0;
    end else begin
      cnt <= !act ? '0 : samp ? (done ? '0 : cnt + 1'b1) : cnt;
      if (samp) rx_sr <= rx_nx;
      if (done) rx_data <= rx_nx;
      rx_valid <= done || (rx_valid && !rx_ready);
      tx_sr <= leave ? '0 : ld ? (buf_full ? tx_buf : '0) : shft ? tx_sr << 1 : tx_sr;
      if (wr) tx_buf <= tx_data;
      buf_full <= wr || (buf_full && !ld);
    end
  end
`ifdef SPI_SLAVE_SYNC_ERR_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) err <= 2'b00;
    else err <= (err & {2{~err_clr}}) | err_set;
  end
`else
  logic unused_err;
  assign err = 2'b00;
  assign unused_err = ^{err_clr, err_set};
`endif
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: five slaves (M=8 modes 0-3, M=16 mode 3) driven by a bit-level master against a queue model
module tb_spi_slave_sync;
`ifdef SPI_SLAVE_SYNC_ERR_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic clk, clr;
  logic sclk[5], ss_n[5], mosi[5], miso[5], miso_oe[5];
  logic tx_valid[5], tx_ready[5], rx_valid[5], rx_ready[5], err_clr[5];
  logic [15:0] tx_data[5], rx_data[5];
  logic [1:0] err[5];
  logic [15:0] txq[5][$], mq[5][$], got[5][$];
  logic acc[5], eu[5], eo[5], rv[5];
  logic [15:0] lw[5], wq[$];
  int total = 0, bad = 0;
  for (genvar i = 0; i < 5; i++) begin : g_dut
    localparam int MM = i == 4 ? 16 : 8;
    localparam int MD = i == 4 ? 3 : i;
    logic [MM-1:0] rd;
    assign rx_data[i] = 16'(rd);
    spi_slave_sync #(.M(MM), .MODE(MD)) u_dut (
      .clk(clk), .clr(clr), .sclk(sclk[i]), .ss_n(ss_n[i]), .mosi(mosi[i]),
      .miso(miso[i]), .miso_oe(miso_oe[i]), .tx_data(tx_data[i][MM-1:0]),
      .tx_valid(tx_valid[i]), .tx_ready(tx_ready[i]), .rx_data(rd),
      .rx_valid(rx_valid[i]), .rx_ready(rx_ready[i]), .err(err[i]), .err_clr(err_clr[i])
    );
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int mw(input int g);
    return g == 4 ? 16 : 8;
  endfunction
  function automatic logic cpol(input int g);
    return g == 4 ? 1'b1 : g[1];
  endfunction
  function automatic logic cpha(input int g);
    return g == 4 ? 1'b1 : g[0];
  endfunction
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int g = 0; g < 5; g++) begin
      if (acc[g]) begin
        tx_valid[g] = 1'b0;
        acc[g] = 1'b0;
      end
      if (!tx_valid[g] && txq[g].size() > 0) begin
        tx_data[g] = txq[g].pop_front();
        tx_valid[g] = 1'b1;
      end
      if (tx_valid[g] && tx_ready[g]) acc[g] = 1'b1;
      if (rx_valid[g] && rx_ready[g]) got[g].push_back(rx_data[g]);
    end
  end
  task automatic push(input int g, input logic [15:0] v);
    txq[g].push_back(v);
    mq[g].push_back(v);
    repeat (3) @(negedge clk);
    chk("tx_ready_full", tx_ready[g], 0);
  endtask
  task automatic frame(input int g, input logic [15:0] w[$], input int nbits, input int h, output logic [15:0] cap[$]);
    int m;
    logic [15:0] c;
    logic b;
    m = mw(g);
    c = '0;
    cap = {};
    ss_n[g] = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      b = w[i / m][m - 1 - i % m];
      if (!cpha(g)) begin
        mosi[g] = b;
        repeat (h) @(negedge clk);
        c = {c[14:0], miso[g]};
        sclk[g] = ~cpol(g);
        repeat (h) @(negedge clk);
        sclk[g] = cpol(g);
      end else begin
        sclk[g] = ~cpol(g);
        mosi[g] = b;
        repeat (h) @(negedge clk);
        c = {c[14:0], miso[g]};
        sclk[g] = cpol(g);
        repeat (h) @(negedge clk);
      end
      if (i % m == m - 1) cap.push_back(c & 16'((32'd1 << m) - 1));
    end
    repeat (h + 4) @(negedge clk);
    ss_n[g] = 1'b1;
    mosi[g] = 1'b0;
    repeat (10) @(negedge clk);
  endtask
  // loads pull pending words in order; an empty queue sends zeros and flags underrun
  task automatic run(input int g, input logic [15:0] w[$], input int nbits);
    int m, nc, loads;
    logic [15:0] v;
    logic [15:0] ec[$], eg[$], cap[$];
    m = mw(g);
    nc = nbits / m;
    loads = cpha(g) ? (nbits + m - 1) / m : 1 + nc;
    for (int k = 0; k < loads; k++) begin
      v = '0;
      if (mq[g].size() > 0) v = mq[g].pop_front();
      else eu[g] = 1'b1;
      if (k < nc) ec.push_back(v);
    end
    for (int k = 0; k < nc; k++) begin
      if (rx_ready[g]) eg.push_back(w[k]);
      else begin
        if (rv[g]) eo[g] = 1'b1;
        rv[g] = 1'b1;
        lw[g] = w[k];
      end
    end
    frame(g, w, nbits, $urandom_range(6, 9), cap);
    for (int k = 0; k < nc; k++) chk("miso_word", cap[k], ec[k]);
    chk("rx_count", got[g].size(), eg.size());
    for (int k = 0; k < eg.size() && k < got[g].size(); k++) chk("rx_word", got[g][k], eg[k]);
    got[g] = {};
    if (!rx_ready[g] && rv[g]) begin
      chk("rx_valid_hold", rx_valid[g], 1);
      chk("rx_data_hold", rx_data[g], lw[g]);
    end
    chk("err", err[g], EE ? {eo[g], eu[g]} : 2'b00);
  endtask
  task automatic clr_err(input int g);
    @(negedge clk) err_clr[g] = 1'b1;
    @(negedge clk) err_clr[g] = 1'b0;
    eo[g] = 1'b0;
    eu[g] = 1'b0;
    chk("err_cleared", err[g], 0);
  endtask
  task automatic rand_frame();
    int g, m, nw, np, nb;
    logic [15:0] mask;
    logic [15:0] w[$];
    g = $urandom_range(0, 4);
    m = mw(g);
    mask = 16'((32'd1 << m) - 1);
    nw = $urandom_range(1, 3);
    np = $urandom_range(0, nw + 1);
    nb = nw * m;
    if ($urandom_range(0, 3) == 0) nb -= $urandom_range(1, m - 1);
    w = {};
    for (int k = 0; k < nw; k++) w.push_back(16'($urandom) & mask);
    for (int k = 0; k < np; k++) push(g, 16'($urandom) & mask);
    run(g, w, nb);
    clr_err(g);
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    clr = 1'b1;
    for (int g = 0; g < 5; g++) begin
      sclk[g] = cpol(g);
      ss_n[g] = 1'b1;
      mosi[g] = 1'b0;
      tx_data[g] = '0;
      tx_valid[g] = 1'b0;
      rx_ready[g] = 1'b1;
      err_clr[g] = 1'b0;
      acc[g] = 1'b0;
      eu[g] = 1'b0;
      eo[g] = 1'b0;
      rv[g] = 1'b0;
      lw[g] = '0;
    end
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      chk("rst_tx_ready", tx_ready[g], 1);
      chk("rst_rx_valid", rx_valid[g], 0);
      chk("rst_rx_data", rx_data[g], 0);
      chk("rst_oe", miso_oe[g], 0);
      chk("rst_err", err[g], 0);
    end
    push(0, 16'hA5);
    wq = {16'h3C};
    run(0, wq, 8);
    clr_err(0);
    push(4, 16'h1234);
    push(4, 16'hBEEF);
    wq = {16'h1234, 16'hBEEF};
    run(4, wq, 32);
    wq = {16'h96};
    run(1, wq, 8);
    clr_err(1);
    @(posedge clk);
    #1 rx_ready[2] = 1'b0;
    wq = {16'h11, 16'h22};
    run(2, wq, 16);
    @(posedge clk);
    #1 rx_ready[2] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rx_drain_count", got[2].size(), 1);
    if (got[2].size() > 0) chk("rx_drain_word", got[2][0], 16'h22);
    got[2] = {};
    rv[2] = 1'b0;
    clr_err(2);
    wq = {16'hC3};
    run(0, wq, 5);
    wq = {16'h5A};
    run(0, wq, 8);
    clr_err(0);
    for (int it = 0; it < 14; it++) rand_frame();
    push(0, 16'h77);
    ss_n[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("oe_active", miso_oe[0], 1);
    #3 clr = 1'b1;
    #1;
    chk("clr_miso", miso[0], 0);
    chk("clr_oe", miso_oe[0], 0);
    chk("clr_rx_data", rx_data[0], 0);
    chk("clr_rx_valid", rx_valid[0], 0);
    chk("clr_tx_ready", tx_ready[0], 1);
    chk("clr_err", err[0], 0);
    @(negedge clk);
    ss_n[0] = 1'b1;
    clr = 1'b0;
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
